dmem_ws: RTL and testbench
==========================

# dmem_ws

Parametrised wait-state data memory model for the RISC-V core benches. It replaces the fixed single-cycle behavioural data memory with a request/acknowledge slave that adds configurable latency, byte-enable writes, range and alignment checking, and a memory-mapped end-of-simulation flag. It sits between the core's data port and the bench's clock generator, so the bench ends when the program writes the magic address.

## Interface
- DATA_W, 32: data width in bits; multiple of 8.
- DEPTH_LOG2, 5: log2 of word count (default 32 words = 128 bytes).
- WAIT, 1: wait states, range 0..15.
- END_ADDR, 32'hFFFF_FFFC: byte address whose write sets end_sim_o.

- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_i  in  1  access request; held high until ack_o.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  32  byte address.
- be_i  in  DATA_W/8  byte enables for writes; ignored on reads.
- wdata_i  in  DATA_W  write data.
- ack_o  out  1  one-cycle completion pulse.
- rdata_o  out  DATA_W  read data, valid while ack_o is high.
- err_o  out  1  error flag, valid while ack_o is high.
- end_sim_o  out  1  sticky end-of-simulation flag.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state IDLE. cnt is 4 bits.
- IDLE: if req_i=1, capture we_i/addr_i/be_i/wdata_i, load cnt with the wait count, go to BUSY. Otherwise stay in IDLE.
- BUSY, cnt≠0: decrement cnt.
- BUSY, cnt=0: perform the access from the captured values. Register ack_o=1 plus rdata_o/err_o. Go to DONE.
- DONE: ack_o←0, rdata_o←0, err_o←0; go to IDLE. req_i is not sampled in BUSY or DONE.
- Word index is addr[DEPTH_LOG2+1:2].
- Error (err_o=1, no store, rdata_o=0) when:
  - addr[1:0]≠0, or
  - addr[31:DEPTH_LOG2+2]≠0 and addr≠END_ADDR.
- Write, no error: each lane i with be_i[i]=1 updates byte i. be_i=0 completes with ack and no change.
- Write to END_ADDR with be≠0: sets end_sim_o, err_o=0, no array store. end_sim_o is cleared only by reset.
- Read of END_ADDR: returns 0, err_o=0.
- Array is zero at time 0 and is not cleared by rst_n.

## Timing
- Reset values: ack_o=0, rdata_o=0, err_o=0, end_sim_o=0, state IDLE, cnt=0.
- Latency: req_i sampled at edge k → ack_o high for the cycle following edge k+1+W, where W is the loaded wait count. W=0 gives ack in the cycle after edge k+1.
- Requester must drop req_i at the edge ending the ack cycle. Minimum request spacing is W+3 cycles.
- Read data reflects all writes that completed earlier. A write and a read never coincide.
- rst_n asserted mid-access: pending access is discarded, no store, no ack, state returns to IDLE. This holds in any cycle, including BUSY with cnt=0 at the same edge.

## Configuration
- DMEM_RAND_WAIT_EN defined:
  - 16-bit Fibonacci LFSR with taps 16,14,13,11; reset seed 16'hACE1; advances every cycle.
  - Loaded wait count is min(lfsr[3:0], WAIT), giving random latency in 0..WAIT that is reproducible from reset.
- Not defined: no LFSR, and the wait count is always WAIT.

## Test plan
- Reset, WAIT=1: write addr 0x10, be=4'hF, data 0xDEADBEEF, req at edge k → ack in the cycle after edge k+2, err=0. Reading 0x10 returns 0xDEADBEEF.
- Byte enables: after the above, write 0x10 with be=4'b0101, data 0x11223344 → read returns 0xDE22BE44.
- Errors:
  - read 0x12 → ack with err=1, rdata=0.
  - write 0x80 at DEPTH_LOG2=5 → err=1, word 0 unchanged.
- End of simulation:
  - write END_ADDR, be=4'hF → end_sim_o rises with ack and stays high through later accesses.
  - rst_n low → end_sim_o=0.
- WAIT=0 and WAIT=15 sweep, macro undefined → latency is exactly 1 and 16 edges from sampling to ack. With DMEM_RAND_WAIT_EN, 1000 accesses all show latency within 1..16 edges and data is intact.
- Reset mid-operation: assert rst_n low while in BUSY with a pending write to 0x04 → no ack, word 0x04 unchanged, next request is served normally.

Source files
------------

// File: rtl/dmem_ws.sv
// dmem_ws: request/acknowledge data memory with configurable wait states, byte-enable writes,
// range/alignment errors and a sticky end-of-simulation flag. Optional: DMEM_RAND_WAIT_EN.
module dmem_ws #(
  parameter int          DATA_W     = 32,
  parameter int          DEPTH_LOG2 = 5,
  parameter int          WAIT       = 1,
  parameter logic [31:0] END_ADDR   = 32'hFFFF_FFFC
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [31:0]         addr_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic                ack_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                err_o,
  output logic                end_sim_o
);

  localparam int         NB     = DATA_W / 8;
  localparam int         DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_C = 4'(WAIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic misaligned(input logic [31:0] a);
    return (a[1:0] != 2'b00);
  endfunction

  // Anything above the array is an error unless it is exactly the end-of-sim address.
  function automatic logic out_of_range(input logic [31:0] a);
    return ((a >> (DEPTH_LOG2 + 2)) != 32'd0) && (a != END_ADDR);
  endfunction

  function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] old_w,
                                                    input logic [DATA_W-1:0] new_w,
                                                    input logic [NB-1:0]     be);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return res;
  endfunction

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [31:0]         addr_q, addr_d;
  logic [NB-1:0]       be_q, be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                end_sim_q, end_sim_d;

  logic [3:0]            wait_ld_s;
  logic [DEPTH_LOG2-1:0] idx_s;
  logic                  acc_err_s;
  logic                  acc_end_s;
  logic                  mem_we_s;
  logic [DATA_W-1:0]     mem_q [DEPTH];

`ifdef DMEM_RAND_WAIT_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        lfsr_fb_s;

  // Taps 16,14,13,11 map to bits 15,13,12,10.
  assign lfsr_fb_s = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign lfsr_d    = {lfsr_q[14:0], lfsr_fb_s};
  assign wait_ld_s = (lfsr_q[3:0] < WAIT_C) ? lfsr_q[3:0] : WAIT_C;

  // Free-running LFSR, reproducible from reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign wait_ld_s = WAIT_C;
`endif

  assign idx_s     = addr_q[DEPTH_LOG2+1:2];
  assign acc_err_s = misaligned(addr_q) || out_of_range(addr_q);
  assign acc_end_s = !misaligned(addr_q) && (addr_q == END_ADDR);

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    ack_d     = ack_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    end_sim_d = end_sim_q;
    mem_we_s  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          addr_d  = addr_i;
          be_d    = be_i;
          wdata_d = wdata_i;
          cnt_d   = wait_ld_s;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ack_d   = 1'b1;
          err_d   = 1'b0;
          rdata_d = {DATA_W{1'b0}};
          state_d = DONE;
          if (acc_err_s) begin
            err_d = 1'b1;
          end else if (acc_end_s) begin
            end_sim_d = end_sim_q | (we_q & (be_q != {NB{1'b0}}));
          end else if (we_q) begin
            mem_we_s = (be_q != {NB{1'b0}});
          end else begin
            rdata_d = mem_q[idx_s];
          end
        end
      end
      DONE: begin
        ack_d   = 1'b0;
        rdata_d = {DATA_W{1'b0}};
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        ack_d   = 1'b0;
        rdata_d = {DATA_W{1'b0}};
        err_d   = 1'b0;
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
    endcase
  end

  // Control, capture and output registers; reset discards any pending access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      be_q      <= {NB{1'b0}};
      wdata_q   <= {DATA_W{1'b0}};
      ack_q     <= 1'b0;
      rdata_q   <= {DATA_W{1'b0}};
      err_q     <= 1'b0;
      end_sim_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      end_sim_q <= end_sim_d;
    end
  end

  // Storage array has no reset so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[idx_s] <= merge_lanes(mem_q[idx_s], wdata_q, be_q);
    end
  end

  assign ack_o     = ack_q;
  assign rdata_o   = rdata_q;
  assign err_o     = err_q;
  assign end_sim_o = end_sim_q;

endmodule

// File: tb/tb_dmem_ws.sv
// Scoreboard bench for dmem_ws: three instances (WAIT=1, 0, 15) driven with directed vectors.
module tb_dmem_ws;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req_s     [3];
  logic        we_s      [3];
  logic [31:0] addr_s    [3];
  logic [3:0]  be_s      [3];
  logic [31:0] wdata_s   [3];
  logic        ack_s     [3];
  logic [31:0] rdata_s   [3];
  logic        err_s     [3];
  logic        end_sim_s [3];

  dmem_ws #(.WAIT(1)) u_main (
    .clk(clk), .rst_n(rst_n), .req_i(req_s[0]), .we_i(we_s[0]), .addr_i(addr_s[0]),
    .be_i(be_s[0]), .wdata_i(wdata_s[0]), .ack_o(ack_s[0]), .rdata_o(rdata_s[0]),
    .err_o(err_s[0]), .end_sim_o(end_sim_s[0]));
  dmem_ws #(.WAIT(0)) u_w0 (
    .clk(clk), .rst_n(rst_n), .req_i(req_s[1]), .we_i(we_s[1]), .addr_i(addr_s[1]),
    .be_i(be_s[1]), .wdata_i(wdata_s[1]), .ack_o(ack_s[1]), .rdata_o(rdata_s[1]),
    .err_o(err_s[1]), .end_sim_o(end_sim_s[1]));
  dmem_ws #(.WAIT(15)) u_w15 (
    .clk(clk), .rst_n(rst_n), .req_i(req_s[2]), .we_i(we_s[2]), .addr_i(addr_s[2]),
    .be_i(be_s[2]), .wdata_i(wdata_s[2]), .ack_o(ack_s[2]), .rdata_o(rdata_s[2]),
    .err_o(err_s[2]), .end_sim_o(end_sim_s[2]));

  typedef struct {
    int          dut;
    bit          chk_rd;
    logic [31:0] rdata;
    logic        err;
    logic        end_sim;
    int          k;
    int          lat_min;
    int          lat_max;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic        exp_end [3];
  logic [31:0] last_wd [32];

  always @(posedge clk) cyc++;

  function automatic int wait_of(input int d);
    case (d)
      0: return 1;
      1: return 0;
      default: return 15;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every ack and checks data, error, flag and latency.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (ack_s[d] === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL spurious_ack dut%0d: ack=1 expected no ack", d);
        end else begin
          mon_e = sb.pop_front();
          chk("ack_dut", d, mon_e.dut);
          if (mon_e.chk_rd) chk("rdata", rdata_s[d], mon_e.rdata);
          chk("err", {31'd0, err_s[d]}, {31'd0, mon_e.err});
          chk("end_sim", {31'd0, end_sim_s[d]}, {31'd0, mon_e.end_sim});
          n_cmp++;
          if ((cyc - mon_e.k) < mon_e.lat_min || (cyc - mon_e.k) > mon_e.lat_max) begin
            n_fail++;
            $display("FAIL latency dut%0d: got %0d edges expected %0d..%0d", d,
                     cyc - mon_e.k, mon_e.lat_min, mon_e.lat_max);
          end
        end
      end
    end
  end

  task automatic access(input int d, input bit wr, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd, input logic [31:0] erd, input bit eerr);
    exp_t e;
    int   w;
    bit   got;
    @(negedge clk);
    w         = wait_of(d);
    e.dut     = d;
    e.chk_rd  = !wr;
    e.rdata   = erd;
    e.err     = eerr;
    e.end_sim = exp_end[d];
    e.k       = cyc + 1;
`ifdef DMEM_RAND_WAIT_EN
    e.lat_min = 1;
`else
    e.lat_min = w + 1;
`endif
    e.lat_max = w + 1;
    sb.push_back(e);
    we_s[d]    = wr;
    addr_s[d]  = a;
    be_s[d]    = be;
    wdata_s[d] = wd;
    req_s[d]   = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      if (ack_s[d] === 1'b1) got = 1'b1;
    end
    req_s[d] = 1'b0;
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ack_timeout dut%0d addr %h: got no ack expected ack", d, a);
      e = sb.pop_back();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] wd;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      req_s[d] = 1'b0; we_s[d] = 1'b0; addr_s[d] = 32'd0;
      be_s[d] = 4'h0; wdata_s[d] = 32'd0; exp_end[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'd0, ack_s[0]}, 32'd0);
    chk("rst_rdata", rdata_s[0], 32'd0);
    chk("rst_err", {31'd0, err_s[0]}, 32'd0);
    chk("rst_end_sim", {31'd0, end_sim_s[0]}, 32'd0);
    rst_n = 1'b1;

    // Directed vectors on the WAIT=1 instance.
    access(0, 1'b1, 32'h0000_0000, 4'hF, 32'hA5A5_5A5A, 32'h0, 1'b0);
    access(0, 1'b1, 32'h0000_0004, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0);
    access(0, 1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0);
    access(0, 1'b0, 32'h0000_0010, 4'h0, 32'h0,         32'hDEAD_BEEF, 1'b0);
    access(0, 1'b1, 32'h0000_0010, 4'b0101, 32'h1122_3344, 32'h0, 1'b0);
    access(0, 1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'hDE22_BE44, 1'b0);
    access(0, 1'b0, 32'h0000_0012, 4'hF, 32'h0,         32'h0, 1'b1);
    access(0, 1'b1, 32'h0000_0080, 4'hF, 32'h1234_5678, 32'h0, 1'b1);
    access(0, 1'b0, 32'h0000_0000, 4'h0, 32'h0,         32'hA5A5_5A5A, 1'b0);
    access(0, 1'b1, 32'h0000_0010, 4'h0, 32'hFFFF_FFFF, 32'h0, 1'b0);
    access(0, 1'b0, 32'h0000_0010, 4'h0, 32'h0,         32'hDE22_BE44, 1'b0);
    access(0, 1'b0, 32'hFFFF_FFFC, 4'h0, 32'h0,         32'h0, 1'b0);
    access(0, 1'b1, 32'h0000_007C, 4'hF, 32'h0BAD_F00D, 32'h0, 1'b0);
    access(0, 1'b0, 32'h0000_007C, 4'h0, 32'h0,         32'h0BAD_F00D, 1'b0);
    access(0, 1'b0, 32'hFFFF_FFF8, 4'h0, 32'h0,         32'h0, 1'b1);
    exp_end[0] = 1'b1;
    access(0, 1'b1, 32'hFFFF_FFFC, 4'hF, 32'h0000_0001, 32'h0, 1'b0);
    access(0, 1'b0, 32'h0000_0010, 4'h0, 32'h0,         32'hDE22_BE44, 1'b0);

    // Reset while a write to 0x04 is still in BUSY.
    @(negedge clk);
    we_s[0] = 1'b1; addr_s[0] = 32'h0000_0004; be_s[0] = 4'hF; wdata_s[0] = 32'h5555_5555;
    req_s[0] = 1'b1;
    @(negedge clk);
`ifndef DMEM_RAND_WAIT_EN
    @(negedge clk);
`endif
    rst_n = 1'b0;
    req_s[0] = 1'b0;
    @(negedge clk);
    chk("midrst_end_sim", {31'd0, end_sim_s[0]}, 32'd0);
    chk("midrst_ack", {31'd0, ack_s[0]}, 32'd0);
    rst_n = 1'b1;
    exp_end[0] = 1'b0;
    access(0, 1'b0, 32'h0000_0004, 4'h0, 32'h0, 32'hCAFE_F00D, 1'b0);

    // WAIT=0 instance.
    access(1, 1'b1, 32'h0000_0008, 4'hF, 32'h0102_0304, 32'h0, 1'b0);
    access(1, 1'b0, 32'h0000_0008, 4'h0, 32'h0, 32'h0102_0304, 1'b0);
    access(1, 1'b0, 32'h0000_0009, 4'h0, 32'h0, 32'h0, 1'b1);
    access(1, 1'b1, 32'h0000_0008, 4'b1000, 32'hFF00_0000, 32'h0, 1'b0);
    access(1, 1'b0, 32'h0000_0008, 4'h0, 32'h0, 32'hFF02_0304, 1'b0);

    // WAIT=15 instance: 1000 accesses, then read every word back.
    for (int i = 0; i < 500; i++) begin
      wd = (32'(i) * 32'h9E37_79B9) ^ 32'h1234_5678;
      last_wd[i % 32] = wd;
      access(2, 1'b1, 32'((i % 32) * 4), 4'hF, wd, 32'h0, 1'b0);
      access(2, 1'b0, 32'((i % 32) * 4), 4'h0, 32'h0, wd, 1'b0);
    end
    for (int j = 0; j < 32; j++) begin
      access(2, 1'b0, 32'(j * 4), 4'h0, 32'h0, last_wd[j], 1'b0);
    end

    repeat (20) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
